// File: rtl/sap_pkg.sv
// sap_pkg: definitions shared across the SAP-series CPU blocks.
//   - state_t      : main-memory sequencer states (CLEAR, RUN, PROG)
//   - DATA_W_DEF / ADDR_W_DEF : default word/address widths shared with MAR, PC, IR
//   - OP_*         : 4-bit opcodes in the upper nibble of an instruction word
//   - mk_instr()   : packs {opcode, operand} into one instruction word
package sap_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_PROG  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [7:0] mk_instr(input logic [3:0] op, input logic [3:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/sap_ram_core.sv
// sap_ram_core: single-port synchronous RAM, DEPTH = 2**ADDR_W words.
//   clk   : clock, all updates on the rising edge
//   rst   : synchronous active-high, clears only the read register
//   addr  : shared read/write address
//   we    : write enable, mem[addr] <= wdata
//   wdata : write data
//   re    : read enable; when low rd_q holds
//   rd_q  : registered read data (1-cycle latency)
// A read and a write to the same address in one cycle returns the old word:
// both happen on the same edge and the read samples the array before the
// non-blocking write lands.
module sap_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  output logic [DATA_W-1:0] rd_q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array has no reset: contents are cleared by the sequencer above, or
  // deliberately retained across reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rd_q <= '0;
    else if (re) rd_q <= mem[addr];
  end

endmodule

// File: rtl/sap_ram_prog.sv
// sap_ram_prog: SAP main memory with run-time program load.
//   clk, rst    : clock; synchronous active-high reset (wins over everything)
//   mem_addr    : MAR address used in RUN
//   rd_en_n     : active-low bus enable; 1 leaves w_bus high-Z
//   wr_en       : RUN write strobe, wr_data -> ram[mem_addr]
//   wr_data     : RUN write data
//   w_bus       : registered read data, tri-stated onto the W bus
//   prog_mode   : request/hold program-load mode
//   prog_valid  : prog_data holds a word
//   prog_data   : program word
//   prog_ready  : a word is accepted this cycle when prog_valid is also high
//   prog_done   : all DEPTH words loaded in this PROG session
//   busy        : CLEAR or PROG active; CPU must hold
// Sequencer: CLEAR zeroes one word per cycle, RUN serves the CPU, PROG
// streams words into consecutive addresses from 0.
module sap_ram_prog
  import sap_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              rd_en_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output wire  [DATA_W-1:0] w_bus,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              busy
);

  localparam int              DEPTH = 1 << ADDR_W;
  // Counters are one bit wider than the address so the last word is a
  // plain compare and the counter parks at DEPTH without wrapping.
  localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W:0]   clr_addr;
  logic [ADDR_W:0]   prog_addr;
  logic              prog_accept;

  logic [ADDR_W-1:0] core_addr;
  logic              core_we;
  logic [DATA_W-1:0] core_wdata;
  logic              core_re;
  logic [DATA_W-1:0] rd_q;

  assign prog_ready  = (state == ST_PROG) && !prog_done;
  assign prog_accept = prog_valid && prog_ready;
  assign busy        = (state != ST_RUN);

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr  <= '0;
      prog_addr <= '0;
      prog_done <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST) state <= ST_RUN;
        end
        ST_RUN: begin
          if (prog_mode) begin
            state     <= ST_PROG;
            prog_addr <= '0;
            prog_done <= 1'b0;
          end
        end
        ST_PROG: begin
          if (prog_accept) begin
            prog_addr <= prog_addr + 1'b1;
            if (prog_addr == LAST) prog_done <= 1'b1;
          end
          // Exit after the accept above: a word taken on the falling
          // prog_mode cycle is still written, and prog_done clears.
          if (!prog_mode) begin
            state     <= ST_RUN;
            prog_done <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Address / write-port mux into the single-port core
  // ---------------------------------------------------------------------
  always_comb begin
    core_addr  = mem_addr;
    core_we    = 1'b0;
    core_wdata = wr_data;
    core_re    = 1'b0;
    case (state)
      ST_CLEAR: begin
        core_addr  = clr_addr[ADDR_W-1:0];
        core_we    = 1'b1;
        core_wdata = '0;
      end
      ST_RUN: begin
        core_addr  = mem_addr;
        core_we    = wr_en;
        core_wdata = wr_data;
        core_re    = 1'b1;
      end
      ST_PROG: begin
        core_addr  = prog_addr[ADDR_W-1:0];
        core_we    = prog_accept;
        core_wdata = prog_data;
      end
      default: ;
    endcase
    // Reset beats any write, including a handshake in flight.
    if (rst) core_we = 1'b0;
  end

  sap_ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .addr (core_addr),
    .we   (core_we),
    .wdata(core_wdata),
    .re   (core_re),
    .rd_q (rd_q)
  );

  // Only RUN may drive the bus; CLEAR and PROG float it whatever rd_en_n says.
  assign w_bus = (state == ST_RUN && !rd_en_n) ? rd_q : {DATA_W{1'bz}};

endmodule
